// File: rtl/io_arbiter.sv
// io_arbiter: shares the IO/data bus between the CPU port and the image-scan engine,
// with CPU priority, scan anti-starvation and address-decoded region enables.
module io_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MEM_MAX    = 96,
    parameter int SHOW_BASE  = 100,
    parameter int SHOW_END   = 116,
    parameter int ORIG_BASE  = 120,
    parameter int ORIG_END   = 129,
    parameter int PROC_BASE  = 130,
    parameter int PROC_END   = 140,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sel,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              mem_enb,
    output logic              show_enb,
    output logic              original_enb,
    output logic              process_enb
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] L_MEM = ADDR_W'(MEM_MAX);
    localparam logic [ADDR_W-1:0] L_SB  = ADDR_W'(SHOW_BASE);
    localparam logic [ADDR_W-1:0] L_SE  = ADDR_W'(SHOW_END);
    localparam logic [ADDR_W-1:0] L_OB  = ADDR_W'(ORIG_BASE);
    localparam logic [ADDR_W-1:0] L_OE  = ADDR_W'(ORIG_END);
    localparam logic [ADDR_W-1:0] L_PB  = ADDR_W'(PROC_BASE);
    localparam logic [ADDR_W-1:0] L_PE  = ADDR_W'(PROC_END);
    localparam logic [SW-1:0]     L_SM  = SW'(STARVE_MAX);

    typedef enum logic [1:0] {S_IDLE, S_ORIG, S_PROC, S_DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [SW-1:0]     r_starve;
    logic              r_scan_inflight;
    logic              r_pix_valid;
    logic              r_pix_sel;
    logic [DATA_W-1:0] r_pix_data;
    logic              r_cpu_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic              r_scan_done;

    logic              w_scan_req;
    logic              w_cpu_win;
    logic              w_scan_win;
    logic              w_pix_accept;
    logic [ADDR_W-1:0] w_addr;
    logic              w_mem;
    logic              w_show;
    logic              w_orig;
    logic              w_proc;

    // Scan asks only when its next word has somewhere to land and nothing is outstanding.
    assign w_scan_req   = (r_state == S_ORIG || r_state == S_PROC) && (!r_pix_valid || pix_ready) && !r_scan_inflight;
    assign w_cpu_win    = rst_n && cpu_req && !(w_scan_req && r_starve == L_SM);
    assign w_scan_win   = rst_n && w_scan_req && !w_cpu_win;
    assign w_pix_accept = r_pix_valid && pix_ready;
    assign w_addr       = w_cpu_win ? cpu_addr : w_scan_win ? r_cnt : '0;

    assign w_mem  = (w_cpu_win || w_scan_win) && w_addr <= L_MEM;
    assign w_show = w_addr >= L_SB && w_addr <= L_SE;
    assign w_orig = w_addr >= L_OB && w_addr <= L_OE;
    assign w_proc = w_addr >= L_PB && w_addr <= L_PE;

    assign cpu_gnt      = w_cpu_win;
    assign bus_addr     = w_addr;
    assign bus_we       = w_cpu_win && cpu_we && (w_mem || w_show || w_orig || w_proc);
    assign bus_wdata    = w_cpu_win ? cpu_wdata : '0;
    assign mem_enb      = w_mem;
    assign show_enb     = w_show;
    assign original_enb = w_orig;
    assign process_enb  = w_proc;
    assign cpu_rdata    = r_cpu_rdata;
    assign cpu_rvalid   = r_cpu_rvalid;
    assign pix_data     = r_pix_data;
    assign pix_sel      = r_pix_sel;
    assign pix_valid    = r_pix_valid;
    assign scan_busy    = r_state != S_IDLE;
    assign scan_done    = r_scan_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= L_OB;
            r_starve        <= '0;
            r_scan_inflight <= 1'b0;
            r_pix_valid     <= 1'b0;
            r_pix_sel       <= 1'b0;
            r_pix_data      <= '0;
            r_cpu_rvalid    <= 1'b0;
            r_cpu_rdata     <= '0;
            r_scan_done     <= 1'b0;
        end else begin
            r_scan_inflight <= w_scan_win;
            r_cpu_rvalid    <= w_cpu_win && !cpu_we;
            r_starve        <= (w_scan_req && !w_scan_win) ? r_starve + 1'b1 : '0;
            r_scan_done     <= 1'b0;
            if (w_cpu_win && !cpu_we)
                r_cpu_rdata <= bus_rdata;
            if (w_scan_win) begin
                r_pix_valid <= 1'b1;
                r_pix_data  <= bus_rdata;
                r_pix_sel   <= r_state == S_PROC;
            end else if (w_pix_accept)
                r_pix_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (scan_start) begin
                    r_state <= S_ORIG;
                    r_cnt   <= L_OB;
                end
                S_ORIG: if (w_scan_win) begin
                    r_cnt   <= (r_cnt == L_OE) ? L_PB : r_cnt + 1'b1;
                    r_state <= (r_cnt == L_OE) ? S_PROC : S_ORIG;
                end
                S_PROC: if (w_scan_win) begin
                    r_cnt   <= (r_cnt == L_PE) ? L_OB : r_cnt + 1'b1;
                    r_state <= (r_cnt == L_PE) ? S_DRAIN : S_PROC;
                end
                S_DRAIN: if (w_pix_accept) begin
                    r_state     <= S_IDLE;
                    r_scan_done <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
